// File: rtl/cfg_bus_arbiter.sv
// Two-requester arbiter for the frame filter's config/status bus: round-robin
// grant, one-cycle command strobe, read-response routing with a timeout.
module cfg_bus_arbiter #(
  parameter int          TIMEOUT_CYC  = 1023,
  parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_wr,
  input  logic        i_req0_rd,
  input  logic [18:0] iv_req0_addr,
  input  logic        i_req0_addr_fixed,
  input  logic [31:0] iv_req0_wdata,
  output logic        o_req0_ack,
  output logic        o_req0_rdata_valid,
  output logic        o_req0_timeout,
  output logic [31:0] ov_req0_rdata,
  input  logic        i_req1_wr,
  input  logic        i_req1_rd,
  input  logic [18:0] iv_req1_addr,
  input  logic        i_req1_addr_fixed,
  input  logic [31:0] iv_req1_wdata,
  output logic        o_req1_ack,
  output logic        o_req1_rdata_valid,
  output logic        o_req1_timeout,
  output logic [31:0] ov_req1_rdata,
  output logic [18:0] ov_addr,
  output logic        o_addr_fixed,
  output logic [31:0] ov_wdata,
  output logic        o_wr,
  output logic        o_rd,
  input  logic        i_rdata_wr,
  input  logic [18:0] iv_rdata_addr,
  input  logic [31:0] iv_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        last, gnt, is_rd;
  logic [15:0] cnt;

  logic pend0, pend1, gnt_nxt, rd_sel, rsp_hit, to_hit;

  always_comb begin
    pend0   = i_req0_wr | i_req0_rd;
    pend1   = i_req1_wr | i_req1_rd;
    // Under contention the requester not served last wins.
    gnt_nxt = (pend0 && pend1) ? ~last : pend1;
    // wr takes precedence when a requester raises both.
    rd_sel  = gnt_nxt ? (i_req1_rd & ~i_req1_wr) : (i_req0_rd & ~i_req0_wr);
    // ov_addr still holds the latched command address while waiting.
    rsp_hit = i_rdata_wr && (iv_rdata_addr == ov_addr);
    to_hit  = (cnt == CNT_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      last               <= 1'b1;
      gnt                <= 1'b0;
      is_rd              <= 1'b0;
      cnt                <= '0;
      ov_addr            <= '0;
      o_addr_fixed       <= 1'b0;
      ov_wdata           <= '0;
      o_wr               <= 1'b0;
      o_rd               <= 1'b0;
      o_busy             <= 1'b0;
      o_req0_ack         <= 1'b0;
      o_req0_rdata_valid <= 1'b0;
      o_req0_timeout     <= 1'b0;
      ov_req0_rdata      <= '0;
      o_req1_ack         <= 1'b0;
      o_req1_rdata_valid <= 1'b0;
      o_req1_timeout     <= 1'b0;
      ov_req1_rdata      <= '0;
    end else begin
      o_wr               <= 1'b0;
      o_rd               <= 1'b0;
      o_req0_ack         <= 1'b0;
      o_req1_ack         <= 1'b0;
      o_req0_rdata_valid <= 1'b0;
      o_req1_rdata_valid <= 1'b0;
      o_req0_timeout     <= 1'b0;
      o_req1_timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            gnt          <= gnt_nxt;
            last         <= gnt_nxt;
            is_rd        <= rd_sel;
            ov_addr      <= gnt_nxt ? iv_req1_addr       : iv_req0_addr;
            o_addr_fixed <= gnt_nxt ? i_req1_addr_fixed  : i_req0_addr_fixed;
            ov_wdata     <= gnt_nxt ? iv_req1_wdata      : iv_req0_wdata;
            // Strobe and ack become visible during the ISSUE cycle.
            o_wr         <= ~rd_sel;
            o_rd         <= rd_sel;
            o_req0_ack   <= ~gnt_nxt;
            o_req1_ack   <= gnt_nxt;
            o_busy       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (is_rd) begin
            state <= WAIT_RD;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        WAIT_RD: begin
          if (rsp_hit || to_hit) begin
            if (gnt) begin
              ov_req1_rdata      <= rsp_hit ? iv_rdata : TIMEOUT_DATA;
              o_req1_rdata_valid <= 1'b1;
              o_req1_timeout     <= ~rsp_hit;
            end else begin
              ov_req0_rdata      <= rsp_hit ? iv_rdata : TIMEOUT_DATA;
              o_req0_rdata_valid <= 1'b1;
              o_req0_timeout     <= ~rsp_hit;
            end
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Directed bench for cfg_bus_arbiter: writes, reads, round-robin, timeout,
// response/timeout collision and mid-read reset.
module tb_cfg_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0_wr, i_req0_rd, i_req0_addr_fixed;
  logic [18:0] iv_req0_addr;
  logic [31:0] iv_req0_wdata;
  logic        o_req0_ack, o_req0_rdata_valid, o_req0_timeout;
  logic [31:0] ov_req0_rdata;
  logic        i_req1_wr, i_req1_rd, i_req1_addr_fixed;
  logic [18:0] iv_req1_addr;
  logic [31:0] iv_req1_wdata;
  logic        o_req1_ack, o_req1_rdata_valid, o_req1_timeout;
  logic [31:0] ov_req1_rdata;
  logic [18:0] ov_addr;
  logic        o_addr_fixed;
  logic [31:0] ov_wdata;
  logic        o_wr, o_rd;
  logic        i_rdata_wr;
  logic [18:0] iv_rdata_addr;
  logic [31:0] iv_rdata;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int r0_evt = 0;
  bit mon0   = 1'b0;

  always #5 i_clk = ~i_clk;

  cfg_bus_arbiter #(.TIMEOUT_CYC(8), .TIMEOUT_DATA(32'hFFFF_FFFF)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_wr(i_req0_wr), .i_req0_rd(i_req0_rd), .iv_req0_addr(iv_req0_addr),
    .i_req0_addr_fixed(i_req0_addr_fixed), .iv_req0_wdata(iv_req0_wdata),
    .o_req0_ack(o_req0_ack), .o_req0_rdata_valid(o_req0_rdata_valid),
    .o_req0_timeout(o_req0_timeout), .ov_req0_rdata(ov_req0_rdata),
    .i_req1_wr(i_req1_wr), .i_req1_rd(i_req1_rd), .iv_req1_addr(iv_req1_addr),
    .i_req1_addr_fixed(i_req1_addr_fixed), .iv_req1_wdata(iv_req1_wdata),
    .o_req1_ack(o_req1_ack), .o_req1_rdata_valid(o_req1_rdata_valid),
    .o_req1_timeout(o_req1_timeout), .ov_req1_rdata(ov_req1_rdata),
    .ov_addr(ov_addr), .o_addr_fixed(o_addr_fixed), .ov_wdata(ov_wdata),
    .o_wr(o_wr), .o_rd(o_rd),
    .i_rdata_wr(i_rdata_wr), .iv_rdata_addr(iv_rdata_addr), .iv_rdata(iv_rdata),
    .o_busy(o_busy)
  );

  // Counts any req0 output activity while a req1-only transaction runs.
  always @(negedge i_clk)
    if (mon0 && (o_req0_ack || o_req0_rdata_valid || o_req0_timeout)) r0_evt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick(2);
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    {i_req0_wr, i_req0_rd, i_req0_addr_fixed, i_req1_wr, i_req1_rd, i_req1_addr_fixed} = '0;
    iv_req0_addr = '0; iv_req0_wdata = '0; iv_req1_addr = '0; iv_req1_wdata = '0;
    i_rdata_wr = 1'b0; iv_rdata_addr = '0; iv_rdata = '0;
    do_reset();

    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_strobes", {30'd0, o_wr, o_rd}, 32'd0);
    chk("rst_addr", 32'(ov_addr), 32'd0);
    chk("rst_acks", {30'd0, o_req0_ack, o_req1_ack}, 32'd0);

    // req0 write
    i_req0_wr = 1'b1; iv_req0_addr = 19'h00010; iv_req0_wdata = 32'hA5A5_0001;
    i_req0_addr_fixed = 1'b1;
    tick();
    chk("wr_o_wr", 32'(o_wr), 32'd1);
    chk("wr_o_rd", 32'(o_rd), 32'd0);
    chk("wr_addr", 32'(ov_addr), 32'h10);
    chk("wr_wdata", ov_wdata, 32'hA5A5_0001);
    chk("wr_fixed", 32'(o_addr_fixed), 32'd1);
    chk("wr_ack0", 32'(o_req0_ack), 32'd1);
    chk("wr_ack1", 32'(o_req1_ack), 32'd0);
    chk("wr_busy_issue", 32'(o_busy), 32'd1);
    i_req0_wr = 1'b0; i_req0_addr_fixed = 1'b0;
    tick();
    chk("wr_busy_done", 32'(o_busy), 32'd0);
    chk("wr_strobe_off", 32'(o_wr), 32'd0);
    chk("wr_ack_once", 32'(o_req0_ack), 32'd0);
    chk("wr_addr_hold", 32'(ov_addr), 32'h10);

    // req1 read, response 5 cycles after o_rd
    mon0 = 1'b1; r0_evt = 0;
    i_req1_rd = 1'b1; iv_req1_addr = 19'h00020;
    tick();
    chk("rd1_o_rd", 32'(o_rd), 32'd1);
    chk("rd1_o_wr", 32'(o_wr), 32'd0);
    chk("rd1_ack1", 32'(o_req1_ack), 32'd1);
    i_req1_rd = 1'b0;
    tick(4);
    chk("rd1_wait_busy", 32'(o_busy), 32'd1);
    chk("rd1_no_early_valid", 32'(o_req1_rdata_valid), 32'd0);
    i_rdata_wr = 1'b1; iv_rdata_addr = 19'h00020; iv_rdata = 32'h0000_1234;
    tick();
    i_rdata_wr = 1'b0;
    chk("rd1_valid", 32'(o_req1_rdata_valid), 32'd1);
    chk("rd1_data", ov_req1_rdata, 32'h0000_1234);
    chk("rd1_timeout", 32'(o_req1_timeout), 32'd0);
    tick();
    chk("rd1_valid_pulse", 32'(o_req1_rdata_valid), 32'd0);
    chk("rd1_data_hold", ov_req1_rdata, 32'h0000_1234);
    chk("rd1_busy_done", 32'(o_busy), 32'd0);
    mon0 = 1'b0;
    chk("rd1_req0_quiet", 32'(r0_evt), 32'd0);

    // contention from reset: strict alternation, twice
    do_reset();
    iv_req0_addr = 19'h00100; iv_req1_addr = 19'h00200;
    iv_req0_wdata = 32'h0000_0100; iv_req1_wdata = 32'h0000_0200;
    for (int r = 0; r < 2; r++) begin
      i_req0_wr = 1'b1; i_req1_wr = 1'b1;
      tick();
      chk("rr_first_ack0", {30'd0, o_req0_ack, o_req1_ack}, 32'b10);
      chk("rr_first_addr", 32'(ov_addr), 32'h100);
      i_req0_wr = 1'b0;
      tick(2);
      chk("rr_second_ack1", {30'd0, o_req0_ack, o_req1_ack}, 32'b01);
      chk("rr_second_wdata", ov_wdata, 32'h0000_0200);
      i_req1_wr = 1'b0;
      tick();
    end

    // both wr and rd raised: treated as a write
    i_req0_wr = 1'b1; i_req0_rd = 1'b1;
    tick();
    chk("wr_rd_both", {30'd0, o_wr, o_rd}, 32'b10);
    i_req0_wr = 1'b0; i_req0_rd = 1'b0;
    tick();

    // req0 read times out; mismatched response ignored
    i_req0_rd = 1'b1; iv_req0_addr = 19'h00020;
    tick();
    chk("to_o_rd", 32'(o_rd), 32'd1);
    i_req0_rd = 1'b0;
    tick(3);
    i_rdata_wr = 1'b1; iv_rdata_addr = 19'h00021; iv_rdata = 32'hDEAD_BEEF;
    tick();
    i_rdata_wr = 1'b0;
    chk("to_mismatch_ignored", 32'(o_req0_rdata_valid), 32'd0);
    tick(4);
    chk("to_not_yet", {30'd0, o_req0_rdata_valid, o_req0_timeout}, 32'd0);
    tick();
    chk("to_valid_timeout", {30'd0, o_req0_rdata_valid, o_req0_timeout}, 32'b11);
    chk("to_data", ov_req0_rdata, 32'hFFFF_FFFF);
    tick();
    chk("to_pulse_end", {30'd0, o_req0_rdata_valid, o_req0_timeout}, 32'd0);
    chk("to_busy_done", 32'(o_busy), 32'd0);

    // matching response on the timeout threshold cycle
    i_req1_rd = 1'b1; iv_req1_addr = 19'h00030;
    tick();
    i_req1_rd = 1'b0;
    tick(8);
    i_rdata_wr = 1'b1; iv_rdata_addr = 19'h00030; iv_rdata = 32'hCAFE_0005;
    tick();
    i_rdata_wr = 1'b0;
    chk("col_valid", 32'(o_req1_rdata_valid), 32'd1);
    chk("col_timeout", 32'(o_req1_timeout), 32'd0);
    chk("col_data", ov_req1_rdata, 32'hCAFE_0005);
    chk("col_req0_hold", ov_req0_rdata, 32'hFFFF_FFFF);
    tick();

    // reset mid-read, late response, then contention goes to req0
    i_req0_rd = 1'b1; iv_req0_addr = 19'h00040;
    tick();
    i_req0_rd = 1'b0;
    tick(2);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rst_mid_busy", 32'(o_busy), 32'd0);
    chk("rst_mid_rdata", ov_req0_rdata, 32'd0);
    i_rdata_wr = 1'b1; iv_rdata_addr = 19'h00040; iv_rdata = 32'h1111_2222;
    tick();
    i_rdata_wr = 1'b0;
    chk("rst_late_rsp", {30'd0, o_req0_rdata_valid, o_busy}, 32'd0);
    tick();
    chk("rst_late_rsp2", 32'(o_req0_rdata_valid), 32'd0);
    i_req0_wr = 1'b1; i_req1_wr = 1'b1;
    tick();
    chk("rst_rr_ptr", {30'd0, o_req0_ack, o_req1_ack}, 32'b10);
    i_req0_wr = 1'b0;
    tick(2);
    i_req1_wr = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
